// File: rtl/code_converter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : code_converter_pipe
// Purpose  : Registered, handshaked code converter for a DIGITS-nibble word.
//            Modes: bin->Gray, BCD->XS3, Gray->bin, XS3->BCD. Invalid
//            BCD/XS3 digits are flagged per digit, forced to zero and
//            counted in a saturating error counter.
// Revision : 1.0 - initial parametrised pipelined release
// ============================================================================
module code_converter_pipe #(
    parameter int DIGITS    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*DIGITS-1:0]    in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*DIGITS-1:0]    out_data,
    output logic [1:0]             out_mode,
    output logic                   out_err,
    output logic [DIGITS-1:0]      out_err_mask,
    output logic [ERR_CNT_W-1:0]   err_count,
    input  logic                   clr_err_count
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] c_mode_bin2gray = 2'b00;
    localparam logic [1:0] c_mode_bcd2xs3  = 2'b01;
    localparam logic [1:0] c_mode_gray2bin = 2'b10;
    localparam logic [1:0] c_mode_xs32bcd  = 2'b11;

    localparam logic [ERR_CNT_W-1:0] c_cnt_max = '1;

    logic [W-1:0]          r_out_data;
    logic [1:0]            r_out_mode;
    logic [DIGITS-1:0]     r_out_mask;
    logic                  r_out_valid;
    logic [ERR_CNT_W-1:0]  r_err_count;

    logic [W-1:0]          w_gray;
    logic [W-1:0]          w_bin;
    logic [W-1:0]          w_xs3;
    logic [W-1:0]          w_bcd;
    logic [DIGITS-1:0]     w_xs3_err;
    logic [DIGITS-1:0]     w_bcd_err;
    logic [W-1:0]          w_conv;
    logic [DIGITS-1:0]     w_mask;
    logic                  w_accept;
    logic [ERR_CNT_W-1:0]  w_cnt_base;
    logic [ERR_CNT_W-1:0]  w_cnt_next;

    // A new word may enter whenever the output register is empty or draining
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Binary to Gray across the whole word
    assign w_gray = in_data ^ (in_data >> 1);

    // Gray to binary: each bit is the XOR of all Gray bits at or above it,
    // written as a reduction so there is no bit-to-bit combinational chain
    // inside one vector.
    for (genvar k = 0; k < W; k++) begin : g_gray2bin
        assign w_bin[k] = ^(in_data >> k);
    end

    // Independent per-digit BCD/XS3 conversion with validity flags
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] w_d;
        logic       w_xs3_ok;
        logic       w_bcd_ok;
        assign w_d      = in_data[4*i +: 4];
        assign w_xs3_ok = (w_d <= 4'd9);
        assign w_bcd_ok = (w_d >= 4'd3) && (w_d <= 4'd12);
        assign w_xs3[4*i +: 4] = w_xs3_ok ? (w_d + 4'd3) : 4'h0;
        assign w_bcd[4*i +: 4] = w_bcd_ok ? (w_d - 4'd3) : 4'h0;
        assign w_xs3_err[i]    = !w_xs3_ok;
        assign w_bcd_err[i]    = !w_bcd_ok;
    end

    // Select the conversion result and error mask for the current mode
    always_comb begin
        w_conv = w_gray;
        w_mask = '0;
        case (in_mode)
            c_mode_bin2gray: begin
                w_conv = w_gray;
                w_mask = '0;
            end
            c_mode_bcd2xs3: begin
                w_conv = w_xs3;
                w_mask = w_xs3_err;
            end
            c_mode_gray2bin: begin
                w_conv = w_bin;
                w_mask = '0;
            end
            c_mode_xs32bcd: begin
                w_conv = w_bcd;
                w_mask = w_bcd_err;
            end
            default: begin
                w_conv = w_gray;
                w_mask = '0;
            end
        endcase
    end

    // Clear takes effect before the increment so clear+error yields one
    always_comb begin
        w_cnt_base = clr_err_count ? '0 : r_err_count;
        w_cnt_next = w_cnt_base;
        if (w_accept && (|w_mask) && (w_cnt_base != c_cnt_max)) begin
            w_cnt_next = w_cnt_base + 1'b1;
        end
    end

    // Output register: load on accept, drop valid once the sink takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mode  <= 2'b00;
            r_out_mask  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_conv;
            r_out_mode  <= in_mode;
            r_out_mask  <= w_mask;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating count of accepted words that carried an invalid digit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else begin
            r_err_count <= w_cnt_next;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_mode     = r_out_mode;
    assign out_err_mask = r_out_mask;
    assign out_err      = |r_out_mask;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_code_converter_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_converter_pipe
// Purpose  : Directed self-checking bench for code_converter_pipe with a
//            scoreboard queue of expected output words.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_code_converter_pipe;

    localparam int DIGITS    = 4;
    localparam int ERR_CNT_W = 2;
    localparam int W         = 4 * DIGITS;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [W-1:0]          in_data = '0;
    logic [1:0]            in_mode = 2'b00;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [W-1:0]          out_data;
    logic [1:0]            out_mode;
    logic                  out_err;
    logic [DIGITS-1:0]     out_err_mask;
    logic [ERR_CNT_W-1:0]  err_count;
    logic                  clr_err_count = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    // Scoreboard entry: {mode, mask, data}
    logic [2+DIGITS+W-1:0] sb_q[$];

    always #5 clk = ~clk;

    code_converter_pipe #(
        .DIGITS   (DIGITS),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mode     (out_mode),
        .out_err      (out_err),
        .out_err_mask (out_err_mask),
        .err_count    (err_count),
        .clr_err_count(clr_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference conversion written bit-by-bit / digit-by-digit
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] m,
                                           output logic [DIGITS-1:0] mask);
        logic [W-1:0] r;
        logic [3:0]   dig;
        r    = '0;
        mask = '0;
        case (m)
            2'b00: r = d ^ (d >> 1);
            2'b10: begin
                r[W-1] = d[W-1];
                for (int k = W - 2; k >= 0; k--) r[k] = r[k+1] ^ d[k];
            end
            2'b01: begin
                for (int i = 0; i < DIGITS; i++) begin
                    dig = d[4*i +: 4];
                    if (dig <= 4'd9) r[4*i +: 4] = dig + 4'd3;
                    else begin r[4*i +: 4] = 4'h0; mask[i] = 1'b1; end
                end
            end
            default: begin
                for (int i = 0; i < DIGITS; i++) begin
                    dig = d[4*i +: 4];
                    if (dig >= 4'd3 && dig <= 4'd12) r[4*i +: 4] = dig - 4'd3;
                    else begin r[4*i +: 4] = 4'h0; mask[i] = 1'b1; end
                end
            end
        endcase
        return r;
    endfunction

    // One clock: settle inputs, score handshakes, advance, then check state
    task automatic cycle(output bit acc);
        logic [2+DIGITS+W-1:0] e;
        logic [DIGITS-1:0]     m;
        logic [W-1:0]          r;
        #1;
        acc = rst_n && in_valid && in_ready;
        if (rst_n) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (sb_q.size() == 0) || out_ready});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", {16'd0, out_data}, {16'd0, e[W-1:0]});
                    chk("out_mode", {30'd0, out_mode}, {30'd0, e[2+DIGITS+W-1 -: 2]});
                    chk("out_mask", {28'd0, out_err_mask}, {28'd0, e[W +: DIGITS]});
                    chk("out_err", {31'd0, out_err}, {31'd0, |e[W +: DIGITS]});
                end
            end
            if (clr_err_count) exp_cnt = 0;
            if (acc) begin
                r = model(in_data, in_mode, m);
                sb_q.push_back({in_mode, m, r});
                if (m != '0 && exp_cnt < CNT_MAX) exp_cnt++;
            end
        end else begin
            sb_q.delete();
            exp_cnt = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
        chk("err_count", {30'd0, err_count}, exp_cnt);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] m);
        bit a;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        cycle(a);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        bit a;
        in_valid = 1'b0;
        cycle(a);
    endtask

    logic [W-1:0] bw [3];
    int idx;
    bit acc;

    initial begin
        bw[0] = 16'h0001;
        bw[1] = 16'h00F0;
        bw[2] = 16'h8000;

        // Reset
        @(posedge clk);
        #1;
        idle();
        idle();
        rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {16'd0, out_data}, 0);
        chk("rst_out_mode", {30'd0, out_mode}, 0);
        chk("rst_out_err", {31'd0, out_err}, 0);
        chk("rst_out_mask", {28'd0, out_err_mask}, 0);
        chk("rst_err_count", {30'd0, err_count}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);

        // Gray round trip
        out_ready = 1'b1;
        send(16'h1234, 2'b00);
        chk("b2g_data", {16'd0, out_data}, 32'h1B2E);
        chk("b2g_err", {31'd0, out_err}, 0);
        send(16'h1B2E, 2'b10);
        chk("g2b_data", {16'd0, out_data}, 32'h1234);

        // BCD/XS3 round trip, no errors
        send(16'h0937, 2'b01);
        chk("xs3_data", {16'd0, out_data}, 32'h3C6A);
        chk("xs3_mask", {28'd0, out_err_mask}, 0);
        send(16'h3C6A, 2'b11);
        chk("bcd_data", {16'd0, out_data}, 32'h0937);
        chk("bcd_mask", {28'd0, out_err_mask}, 0);

        // Invalid digits
        send(16'h12A4, 2'b01);
        chk("xs3_bad_data", {16'd0, out_data}, 32'h4507);
        chk("xs3_bad_mask", {28'd0, out_err_mask}, 32'b0010);
        chk("xs3_bad_cnt", {30'd0, err_count}, 1);
        send(16'h3D02, 2'b11);
        chk("bcd_bad_data", {16'd0, out_data}, 32'h0000);
        chk("bcd_bad_mask", {28'd0, out_err_mask}, 32'b0111);
        chk("bcd_bad_cnt", {30'd0, err_count}, 2);
        idle();

        // Burst of three with a three-cycle sink stall
        idx = 0;
        for (int t = 0; t < 8; t++) begin
            out_ready = !(t >= 1 && t <= 3);
            in_valid  = (idx < 3);
            in_data   = bw[(idx < 3) ? idx : 0];
            in_mode   = 2'b00;
            cycle(acc);
            if (acc) idx++;
            if (t >= 1 && t <= 3) begin
                chk("stall_data", {16'd0, out_data}, 32'h0001);
                chk("stall_in_ready", {31'd0, in_ready}, 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("burst_accepted", idx, 3);
        chk("burst_drained", sb_q.size(), 0);

        // Saturation of the narrow counter, then clear together with an error
        for (int n = 0; n < 5; n++) send(16'hFFFF, 2'b01);
        chk("sat_cnt", {30'd0, err_count}, CNT_MAX);
        clr_err_count = 1'b1;
        send(16'hFFFF, 2'b01);
        clr_err_count = 1'b0;
        chk("clr_err_cnt", {30'd0, err_count}, 1);
        idle();

        // Reset while a word is held under backpressure
        send(16'h1234, 2'b01);
        out_ready = 1'b0;
        idle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk("rst2_out_valid", {31'd0, out_valid}, 0);
        chk("rst2_out_data", {16'd0, out_data}, 0);
        chk("rst2_out_mode", {30'd0, out_mode}, 0);
        chk("rst2_out_mask", {28'd0, out_err_mask}, 0);
        chk("rst2_err_count", {30'd0, err_count}, 0);
        chk("rst2_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        idle();
        idle();
        chk("final_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/code_converter_pipe.md
Name: code_converter_pipe

Overview:
Parametrised, registered successor of the team's 4-bit combinational code converter. Converts a DIGITS-nibble word between binary/Gray and BCD/Excess-3 under a per-transfer mode, with a valid/ready handshake on both sides and one cycle of latency. Invalid BCD/XS3 digits are flagged per digit, forced to a defined value (no X), and counted. It sits between a data source and a display/checker sink in the datapath.

Parameters:
DIGITS, 4, number of 4-bit digits; data width W = 4*DIGITS.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  input word valid.
in_ready  out  1  block can accept the input word this cycle.
in_data  in  W  input code word.
in_mode  in  2  00 bin->Gray, 01 BCD->XS3, 10 Gray->bin, 11 XS3->BCD.
out_valid  out  1  output word valid.
out_ready  in  1  sink accepts the output word.
out_data  out  W  converted word.
out_mode  out  2  mode of the held word.
out_err  out  1  OR of out_err_mask.
out_err_mask  out  DIGITS  per-digit invalid flag; bit i corresponds to in_data[4i+3:4i].
err_count  out  ERR_CNT_W  number of accepted words with out_err=1; saturates.
clr_err_count  in  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_mode=0, out_err=0, out_err_mask=0, err_count=0. in_ready is 1 on the first cycle after reset. A word held in the output register is discarded.
- Handshake: in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. On accept: out_* are loaded at the next edge with the conversion of in_data/in_mode, and out_valid=1.
- If out_ready=1 and there is no accept, out_valid clears. If out_valid=1 and out_ready=0, out_data, out_mode and the error flags are held stable.
- Latency: 1 cycle. Throughput: 1 word per cycle when out_ready=1.
- Mode 00: out = in ^ (in >> 1) over the full W bits. No error.
- Mode 10: out[W-1] = in[W-1]; out[k] = out[k+1] ^ in[k] over the full W bits. No error.
- Mode 01, per digit d: if d <= 9, result is d+3; otherwise result is 4'h0 and the mask bit is set.
- Mode 11, per digit d: if 3 <= d <= 12, result is d-3; otherwise result is 4'h0 and the mask bit is set.
- BCD/XS3 digits are independent. There is no inter-digit carry.
- Modes 00 and 10 always load out_err_mask=0.
- err_count increments by 1 on each accepted word whose computed mask is nonzero. It saturates at 2^ERR_CNT_W-1 with no wrap.
- clr_err_count=1 sets err_count to 0. If an erroring word is accepted in the same cycle, err_count becomes 1 (clear first, then count).
- in_mode is sampled only on accept; mode changes between words take effect with no bubble.

Test Plan:
- DIGITS=4, reset, then mode 00 with in_data=16'h1234 -> next cycle out_valid=1, out_data=16'h1B2E, out_err=0. Mode 10 with 16'h1B2E -> 16'h1234.
- Mode 01 with 16'h0937 -> 16'h3C6A, mask 0. Mode 11 with 16'h3C6A -> 16'h0937, mask 0.
- Mode 01 with 16'h12A4 -> out_data=16'h4507, out_err_mask=4'b0010, err_count 0->1. Mode 11 with 16'h3D02 -> 16'h0000, mask 4'b0111, err_count->2.
- Backpressure: send a burst of 3 words back-to-back, with out_ready=0 from cycle 2 for 3 cycles -> in_ready=0, out_data stable while stalled; all 3 words delivered in order with none lost or duplicated.
- ERR_CNT_W=2: 5 erroring words -> err_count stops at 3. clr_err_count asserted together with an erroring accept -> err_count=1.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle all outputs are 0 and in_ready=1; the held word is never presented.
